// File: rtl/req_latch.sv
// Request capture and snapshot presenter for a 4-bit MSB-first priority encoder.
// Optional feature: define REQ_LATCH_DROP_CNT_EN to build the saturating drop counter.
module req_latch #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:1] req_in,
  output logic [4:1] x,
  output logic       valid,
  input  logic       ack,
  output logic [3:0] drop_cnt
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PRESENT = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;

  logic [4:1] r_sync [SYNC_STAGES];
  logic [4:1] r_dly;
  logic [4:1] r_pend;
  logic [4:1] r_x;
  logic       r_valid;
  logic [1:0] r_state;

  logic [4:1] w_edge;
  logic [4:1] w_clr;
  logic [4:1] w_pend_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_dly <= '0;
    end else begin
      r_sync[0] <= req_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_dly <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_edge = r_sync[SYNC_STAGES-1] & ~r_dly;

  // Clear only the bit the encoder reported: the highest set bit of the snapshot.
  always_comb begin
    w_clr = '0;
    if (r_state == ST_PRESENT && ack) begin
      casez (r_x)
        4'b1???: w_clr = 4'b1000;
        4'b01??: w_clr = 4'b0100;
        4'b001?: w_clr = 4'b0010;
        4'b0001: w_clr = 4'b0001;
        default: w_clr = '0;
      endcase
    end
  end

  // Set wins over a same-cycle clear.
  assign w_pend_nxt = (r_pend & ~w_clr) | w_edge;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_pend  <= '0;
      r_x     <= '0;
      r_valid <= 1'b0;
    end else begin
      r_pend <= w_pend_nxt;
      case (r_state)
        ST_IDLE: begin
          if (r_pend != '0) begin
            r_x     <= r_pend;
            r_valid <= 1'b1;
            r_state <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (ack) begin
            r_x     <= '0;
            r_valid <= 1'b0;
            r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!ack) r_state <= ST_IDLE;
        end
        default: begin
          r_x     <= '0;
          r_valid <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign x     = r_x;
  assign valid = r_valid;

`ifdef REQ_LATCH_DROP_CNT_EN
  logic [3:0] r_drop_cnt;
  logic       w_drop;

  // Any number of lost edges in one cycle counts once.
  assign w_drop = |(w_edge & r_pend & ~w_clr);

  always_ff @(posedge clk) begin
    if (!rst_n)                          r_drop_cnt <= '0;
    else if (w_drop && r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 4'd1;
  end

  assign drop_cnt = r_drop_cnt;
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_req_latch.sv
// Bench for req_latch: directed scenarios with literal expectations plus random
// stimulus compared every cycle against a sample-history reference model.
module tb_req_latch;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:1] req_in;
  logic [4:1] x;
  logic       valid;
  logic       ack;
  logic [3:0] drop_cnt;

  int total = 0;
  int bad   = 0;

  req_latch #(.SYNC_STAGES(S)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_in   (req_in),
    .x        (x),
    .valid    (valid),
    .ack      (ack),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [4:1] top_bit(input logic [4:1] v);
    for (int i = 4; i >= 1; i--) if (v[i]) return 4'(1 << (i - 1));
    return '0;
  endfunction

  // Reference model: edge at clock n is the req_in sample from clock n-S rising
  // relative to the sample from clock n-S-1 (samples before reset release are 0).
  logic [4:1] samp[$];
  logic [4:1] m_pend, m_x;
  logic       m_valid, m_release, m_ready = 1'b0;
  int         m_cnt;

  always @(posedge clk) begin
    logic [4:1] e, a, b, clr;
    int n;
    if (!rst_n) begin
      samp.delete();
      m_pend = '0; m_x = '0; m_valid = 1'b0; m_release = 1'b0; m_cnt = 0;
    end else begin
      samp.push_back(req_in);
      n = samp.size();
      a = (n - S >= 1)     ? samp[n-S-1] : 4'b0;
      b = (n - S - 1 >= 1) ? samp[n-S-2] : 4'b0;
      e = a & ~b;
      clr = '0;
      if (m_valid && ack) begin
        clr = top_bit(m_x);
        m_valid = 1'b0; m_x = '0; m_release = 1'b1;
      end else if (m_release) begin
        if (!ack) m_release = 1'b0;
      end else if (!m_valid && m_pend != '0) begin
        m_x = m_pend; m_valid = 1'b1;
      end
      if ((e & m_pend & ~clr) != '0 && m_cnt < 15) m_cnt++;
      m_pend = (m_pend & ~clr) | e;
    end
    m_ready = 1'b1;
  end

  always @(negedge clk) begin
    if (m_ready) begin
      check("x", {1'b0, x} >> 1 << 1 | 4'(x), m_x);
      check("valid", 4'(valid), 4'(m_valid));
`ifdef REQ_LATCH_DROP_CNT_EN
      check("drop_cnt", drop_cnt, 4'(m_cnt));
`else
      check("drop_cnt", drop_cnt, 4'h0);
`endif
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0; req_in = '0; ack = 1'b0;
    tick(2);
    check("reset_x", x, 4'h0);
    check("reset_valid", 4'(valid), 4'h0);
    check("reset_cnt", drop_cnt, 4'h0);

    // Single request latency
    rst_n = 1'b1; req_in = 4'b0010;
    tick(3);
    check("single_not_yet", 4'(valid), 4'h0);
    tick(1);
    check("single_x", x, 4'b0010);
    check("single_valid", 4'(valid), 4'h1);
    ack = 1'b1; tick(1);
    check("single_ack_x", x, 4'h0);
    check("single_ack_valid", 4'(valid), 4'h0);
    ack = 1'b0; tick(1);
    req_in = '0; tick(3);

    // Simultaneous requests served MSB-first
    req_in = 4'b0101; tick(4);
    check("simul_x", x, 4'b0101);
    ack = 1'b1; tick(1);
    ack = 1'b0; tick(2);
    check("simul_second_x", x, 4'b0001);
    ack = 1'b1; tick(1);
    ack = 1'b0; tick(1);
    req_in = '0; tick(3);

    // Drops while bit 1 is held pending
    req_in = 4'b0001; tick(4);
    check("drop_present_x", x, 4'b0001);
    for (int k = 0; k < 20; k++) begin
      req_in = 4'b0000; tick(1);
      req_in = 4'b0001; tick(1);
    end
    tick(3);
    check("drop_freeze_x", x, 4'b0001);
`ifdef REQ_LATCH_DROP_CNT_EN
    check("drop_sat", drop_cnt, 4'hF);
`else
    check("drop_sat", drop_cnt, 4'h0);
`endif
    ack = 1'b1; tick(1);
    ack = 1'b0; tick(1);
    req_in = '0; tick(3);

    // Set-wins: new edge on bit 3 lands on the ack clearing it
    req_in = 4'b0100; tick(4);
    check("setwin_first_x", x, 4'b0100);
    req_in = 4'b0000; tick(2);
    req_in = 4'b0100; tick(2);
    ack = 1'b1; tick(1);
    ack = 1'b0; tick(2);
    check("setwin_again_x", x, 4'b0100);
    check("setwin_again_valid", 4'(valid), 4'h1);
    ack = 1'b1; tick(1);
    ack = 1'b0; tick(1);
    req_in = '0; tick(3);

    // Reset mid-PRESENT
    req_in = 4'b0110; tick(4);
    check("rstmid_x_before", x, 4'b0110);
    rst_n = 1'b0; tick(1);
    check("rstmid_x", x, 4'h0);
    check("rstmid_valid", 4'(valid), 4'h0);
    check("rstmid_cnt", drop_cnt, 4'h0);
    rst_n = 1'b1; req_in = '0; tick(3);
    check("rstmid_stays_idle", 4'(valid), 4'h0);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      for (int i = 1; i <= 4; i++)
        if ($urandom_range(0, 5) == 0) req_in[i] = ~req_in[i];
      ack   = ($urandom_range(0, 2) == 0);
      rst_n = ($urandom_range(0, 299) != 0);
      tick(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/req_latch.md
REQ_LATCH -- requirements
Module: req_latch

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth on req_in; legal values are 2 or 3.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL be updated on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port req_in, input, [4:1]: asynchronous raw request lines, active-high.
REQ-005 The block SHALL have port x, output, [4:1]: frozen pending snapshot that drives the downstream 4-bit priority encoder input.
REQ-006 The block SHALL have port valid, output, 1 bit: x holds a non-zero snapshot awaiting service.
REQ-007 The block SHALL have port ack, input, 1 bit: the consumer has serviced the highest set bit of x.
REQ-008 The block SHALL have port drop_cnt, output, [3:0]: saturating count of lost request events.

Function
REQ-009 The block SHALL pass each req_in bit through SYNC_STAGES flops, then rising-edge detect it against one further delayed copy.
REQ-010 A detected rising edge on bit i SHALL set pending[i] on the same clock edge that the edge is detected.
REQ-011 Priority SHALL be MSB-first (bit 4 highest), matching the encoder, which ignores lower set bits.
REQ-012 The FSM SHALL have states IDLE, PRESENT and HOLD; reset state IDLE.
REQ-013 IDLE: if pending != 0, the FSM SHALL load x <= pending, assert valid and go to PRESENT on the next edge; otherwise x SHALL be 4'b0000 and valid SHALL be 0.
REQ-014 PRESENT: x SHALL be held constant; new edges SHALL update pending only, not x.
REQ-015 PRESENT with ack=1: the FSM SHALL clear the highest set bit of x in pending, deassert valid and go to HOLD.
REQ-016 HOLD: x SHALL be 4'b0000; the FSM SHALL return to IDLE on the first cycle with ack=0.
REQ-017 ack in IDLE or HOLD SHALL be ignored, except that ack=0 is the exit condition from HOLD.
REQ-018 If an edge on bit i and a clear of bit i occur in the same cycle, set SHALL win.
REQ-019 An edge on a bit already pending (and not cleared that cycle) SHALL be dropped, and drop_cnt SHALL increment, saturating at 4'hF.
REQ-020 Multiple simultaneous drops in one cycle SHALL count as one increment.
REQ-021 Minimum service turnaround SHALL be 3 clocks per request: IDLE to PRESENT to HOLD to IDLE.

Reset
REQ-022 With rst_n=0 at a rising clk edge, the block SHALL reset synchronizer flops, pending, x and drop_cnt to 0, set valid to 0 and set the state to IDLE.
REQ-023 Reset asserted mid-PRESENT or mid-HOLD SHALL discard all pending requests; no stale snapshot SHALL appear after release.
REQ-024 During the first SYNC_STAGES+1 cycles after release, a req_in already high SHALL be seen as a rising edge, because the delayed copy resets to 0.

Configuration
REQ-025 With macro REQ_LATCH_DROP_CNT_EN defined, the block SHALL implement drop_cnt per REQ-019 and REQ-020.
REQ-026 With REQ_LATCH_DROP_CNT_EN undefined, drop_cnt SHALL be tied to 4'h0, no counter logic SHALL be present, and all other behaviour SHALL be unchanged.

Verification
REQ-027 Single request: SYNC_STAGES=2, req_in=4'b0010 held -> pending[2] set 3 clocks later, then x=4'b0010 and valid=1 the following clock; ack pulse -> valid=0, x=0, pending=0.
REQ-028 Simultaneous requests: req_in 0000->0101 -> x=0101 frozen; ack clears bit 3 -> next PRESENT shows x=0001; second ack -> pending=0.
REQ-029 Freeze: in PRESENT with x=0001, req_in bit 4 rises -> x stays 0001 until ack; after HOLD->IDLE, x=1000.
REQ-030 Drop and saturation: pulse req_in[1] 20 times while pending[1] is held by withholding ack -> drop_cnt=4'hF with the macro defined, 4'h0 without.
REQ-031 Set-wins collision: align a new edge on bit 3 with the ack clearing bit 3 -> pending[3] remains 1 and a fresh PRESENT follows.
REQ-032 Reset mid-op: rst_n=0 for 1 clock while in PRESENT with x=0110 -> next cycle valid=0, x=0, drop_cnt=0, state IDLE.
